mux_rr: RTL and testbench

MUX_RR -- requirements
Module: mux_rr

---
 rtl/mux_rr.sv | 124 ++++++++++++
 tb/tb_mux_rr.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// mux_rr: N-channel valid/ready multiplexer with a one-entry registered output.
//
// Channel selection is either driven externally by iSel (MODE 0) or by a
// round-robin arbiter (MODE 1). The winning channel's word is captured into
// the output register one clock after the input handshake.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   iData  - NUM_CH packed words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   iValid - per-channel valid
//   oReady - per-channel ready (combinational, at most one bit high)
//   iSel   - channel select, used in MODE 0 only
//   oMux   - registered selected word
//   oValid - oMux holds an undelivered word
//   oChan  - source channel of the word in oMux
//   iReady - downstream ready
module mux_rr #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = 2,
    parameter int MODE       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] iData,
    input  logic [NUM_CH-1:0]            iValid,
    output logic [NUM_CH-1:0]            oReady,
    input  logic [SEL_W-1:0]             iSel,
    output logic [DATA_WIDTH-1:0]        oMux,
    output logic                         oValid,
    output logic [SEL_W-1:0]             oChan,
    input  logic                         iReady
);

    // NUM_CH at the one-bit-wider width used for index arithmetic.
    localparam logic [SEL_W:0] NUM_CH_X = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [DATA_WIDTH-1:0] mux_reg;
    logic [SEL_W-1:0]      chan_reg;
    logic                  valid_reg;
    logic [SEL_W-1:0]      ptr_reg;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic                  load_en;
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_idx;
    logic                  xfer_in;
    logic [SEL_W-1:0]      ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = iData[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The register can accept a word when empty or when it drains this cycle.
    assign load_en = !valid_reg || iReady;

    always_comb begin
        logic [SEL_W:0] scan_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (MODE == 0) begin
            // Select values past the last channel never grant.
            if ({1'b0, iSel} < NUM_CH_X) begin
                if (iValid[iSel]) begin
                    grant_valid = 1'b1;
                    grant_idx   = iSel;
                end
            end
        end else begin
            // Scan ptr, ptr+1, ... modulo NUM_CH; first valid channel wins.
            for (int i = 0; i < NUM_CH; i++) begin
                scan_idx = {1'b0, ptr_reg} + (SEL_W+1)'(i);
                if (scan_idx >= NUM_CH_X) begin
                    scan_idx = scan_idx - NUM_CH_X;
                end
                if (!grant_valid && iValid[scan_idx[SEL_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx[SEL_W-1:0];
                end
            end
        end
    end

    // Nothing is accepted while reset is held.
    assign xfer_in  = grant_valid && load_en && !reset;
    assign ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign oReady[gi] = xfer_in && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            mux_reg   <= '0;
            chan_reg  <= '0;
            valid_reg <= 1'b0;
            ptr_reg   <= '0;
        end else if (xfer_in) begin
            // Covers both a plain load and a back-to-back deliver+reload.
            mux_reg   <= ch_data[grant_idx];
            chan_reg  <= grant_idx;
            valid_reg <= 1'b1;
            if (MODE != 0) begin
                ptr_reg <= ptr_next;
            end
        end else if (iReady) begin
            // Word delivered with nothing to replace it; data/chan are kept.
            valid_reg <= 1'b0;
        end
    end

    assign oMux   = mux_reg;
    assign oChan  = chan_reg;
    assign oValid = valid_reg;

endmodule

// File: tb/tb_mux_rr.sv
module tb_mux_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance a: MODE 0, 4 channels
    logic [127:0] a_iData;
    logic [3:0]   a_iValid, a_oReady;
    logic [1:0]   a_iSel, a_oChan;
    logic [31:0]  a_oMux;
    logic         a_oValid, a_iReady;

    // Instance b: MODE 1 (round-robin), 4 channels
    logic [127:0] b_iData;
    logic [3:0]   b_iValid, b_oReady;
    logic [1:0]   b_iSel, b_oChan;
    logic [31:0]  b_oMux;
    logic         b_oValid, b_iReady;

    // Instance c: MODE 0, 3 channels
    logic [95:0]  c_iData;
    logic [2:0]   c_iValid, c_oReady;
    logic [1:0]   c_iSel, c_oChan;
    logic [31:0]  c_oMux;
    logic         c_oValid, c_iReady;

    mux_rr #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_W(2), .MODE(0)) dut_a (
        .clk(clk), .reset(reset), .iData(a_iData), .iValid(a_iValid),
        .oReady(a_oReady), .iSel(a_iSel), .oMux(a_oMux), .oValid(a_oValid),
        .oChan(a_oChan), .iReady(a_iReady)
    );

    mux_rr #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_W(2), .MODE(1)) dut_b (
        .clk(clk), .reset(reset), .iData(b_iData), .iValid(b_iValid),
        .oReady(b_oReady), .iSel(b_iSel), .oMux(b_oMux), .oValid(b_oValid),
        .oChan(b_oChan), .iReady(b_iReady)
    );

    mux_rr #(.DATA_WIDTH(32), .NUM_CH(3), .SEL_W(2), .MODE(0)) dut_c (
        .clk(clk), .reset(reset), .iData(c_iData), .iValid(c_iValid),
        .oReady(c_oReady), .iSel(c_iSel), .oMux(c_oMux), .oValid(c_oValid),
        .oChan(c_oChan), .iReady(c_iReady)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] %s ok obs=%h", tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_seq [3];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1;

        reset    = 1'b1;
        a_iData  = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
        b_iData  = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
        c_iData  = {32'hC0000002, 32'hC0000001, 32'hC0000000};
        a_iValid = 4'b1111; a_iSel = 2'd0; a_iReady = 1'b1;
        b_iValid = 4'b0000; b_iSel = 2'd0; b_iReady = 1'b1;
        c_iValid = 3'b000;  c_iSel = 2'd0; c_iReady = 1'b1;

        // Reset: no ready, no acceptance, cleared register
        #1;
        chk("rst_oready", 32'(a_oReady), 32'h0);
        step();
        chk("rst_ovalid", 32'(a_oValid), 32'h0);
        chk("rst_omux",   a_oMux,        32'h0);
        chk("rst_ochan",  32'(a_oChan),  32'h0);
        chk("rst_b_ovalid", 32'(b_oValid), 32'h0);

        // MODE 0 select of channel 2
        reset = 1'b0;
        a_iSel = 2'd2; a_iValid = 4'b0100;
        #1;
        chk("m0_oready_ch2", 32'(a_oReady), 32'h4);
        step();
        chk("m0_omux_ch2",  a_oMux,         32'hDEADBEEF);
        chk("m0_ochan_ch2", 32'(a_oChan),   32'd2);
        chk("m0_ovalid",    32'(a_oValid),  32'h1);

        // Backpressure with iSel changed while full
        a_iReady = 1'b0; a_iSel = 2'd1; a_iValid = 4'b0010;
        #1;
        chk("m0_bp_oready", 32'(a_oReady), 32'h0);
        step();
        chk("m0_bp_omux", a_oMux, 32'hDEADBEEF);
        a_iReady = 1'b1;
        #1;
        chk("m0_newsel_oready", 32'(a_oReady), 32'h2);
        step();
        chk("m0_newsel_omux",  a_oMux,       32'h22222222);
        chk("m0_newsel_ochan", 32'(a_oChan), 32'd1);

        // Selected channel not valid: no grant, register drains, data held
        a_iSel = 2'd3; a_iValid = 4'b0100;
        #1;
        chk("m0_nogrant_oready", 32'(a_oReady), 32'h0);
        step();
        chk("m0_drain_ovalid", 32'(a_oValid), 32'h0);
        chk("m0_hold_omux",    a_oMux,        32'h22222222);
        chk("m0_hold_ochan",   32'(a_oChan),  32'd1);
        a_iValid = 4'b0000;

        // NUM_CH=3: iSel=3 is out of range
        c_iSel = 2'd1; c_iValid = 3'b111;
        step();
        chk("c_load_ochan", 32'(c_oChan), 32'd1);
        chk("c_load_omux",  c_oMux,       32'hC0000001);
        c_iSel = 2'd3;
        #1;
        chk("c_sel3_oready", 32'(c_oReady), 32'h0);
        step();
        chk("c_sel3_ovalid", 32'(c_oValid), 32'h0);
        chk("c_sel3_ochan",  32'(c_oChan),  32'd1);

        // MODE 1: all valid, 8 cycles of rotation
        b_iValid = 4'b1111; b_iReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_all_oready_%0d", i), 32'(b_oReady), 32'(4'b0001 << (i % 4)));
            step();
            chk($sformatf("rr_all_ochan_%0d", i), 32'(b_oChan), 32'(i % 4));
            chk($sformatf("rr_all_ovalid_%0d", i), 32'(b_oValid), 32'h1);
        end

        // MODE 1: sparse valid 1010 -> 1,3,1
        b_iValid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rr_sparse_ochan_%0d", i), 32'(b_oChan), 32'(exp_seq[i]));
            chk($sformatf("rr_sparse_omux_%0d", i), b_oMux, 32'hB0000000 + 32'(exp_seq[i]));
        end

        // Backpressure for 5 cycles, then deliver and reload (ptr=2)
        b_iValid = 4'b1111; b_iReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_bp_oready_%0d", i), 32'(b_oReady), 32'h0);
            step();
            chk($sformatf("rr_bp_ochan_%0d", i), 32'(b_oChan), 32'd1);
            chk($sformatf("rr_bp_omux_%0d", i), b_oMux, 32'hB0000001);
        end
        b_iReady = 1'b1;
        #1;
        chk("rr_release_oready", 32'(b_oReady), 32'h4);
        step();
        chk("rr_release_ochan",  32'(b_oChan),  32'd2);
        chk("rr_release_ovalid", 32'(b_oValid), 32'h1);

        // ptr=3: only ch1 valid -> grant 1, ptr becomes 2
        b_iValid = 4'b0010;
        step();
        chk("rr_pre_rst_ochan", 32'(b_oChan), 32'd1);

        // Reset mid-stream with ptr=2 and oValid=1
        reset = 1'b1; b_iValid = 4'b1111;
        #1;
        chk("rr_rst_oready", 32'(b_oReady), 32'h0);
        step();
        chk("rr_rst_ovalid", 32'(b_oValid), 32'h0);
        chk("rr_rst_omux",   b_oMux,        32'h0);
        chk("rr_rst_ochan",  32'(b_oChan),  32'h0);

        // After release, scanning restarts at 0: lowest valid is ch1
        reset = 1'b0; b_iValid = 4'b1110;
        #1;
        chk("rr_post_rst_oready", 32'(b_oReady), 32'h2);
        step();
        chk("rr_post_rst_ochan", 32'(b_oChan), 32'd1);
        chk("rr_post_rst_omux",  b_oMux,       32'hB0000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
